// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI register responder
package spi_pkg;

  localparam int WORD_WIDTH = 8;
  localparam int FRAME_BITS = 2 * WORD_WIDTH;
  localparam int ADDR_W     = WORD_WIDTH - 1;
  localparam int RW_BIT     = WORD_WIDTH - 1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spi_responder_if.sv
// rtl/spi_responder_if.sv - four-wire SPI bus between master and responder
interface spi_responder_if;

  logic SCLK;
  logic CS;
  logic MOSI;
  logic MISO;

  modport master (
    output SCLK,
    output CS,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCLK,
    input  CS,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchronizer with rise/fall detection on the last two samples
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;

  // Edges are masked until the chain has refilled after reset, so a line that
  // was already asserted through reset never looks like a fresh edge.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
    prev_d    = sync_q[STAGES-1];
    vld_d     = vld_q << 1;
    vld_d[0]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 register-protocol slave with fabric notify and read port
module spi_responder
  import spi_pkg::*;
#(
  parameter int                    WORD_WIDTH  = spi_pkg::WORD_WIDTH,
  parameter int                    NUM_REGS    = 16,
  parameter logic [WORD_WIDTH-1:0] ID_VALUE    = 8'hA5,
  parameter int                    SYNC_STAGES = 2,
  localparam int                   HA_W        = $clog2(NUM_REGS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  spi_responder_if.slave        spi,
  output logic                  o_wr_strobe,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [WORD_WIDTH-1:0] o_wr_data,
  output logic                  o_rd_strobe,
  output logic                  o_frame_error,
  output logic                  o_busy,
  input  logic [HA_W-1:0]       i_host_addr,
  output logic [WORD_WIDTH-1:0] o_host_data
);

  localparam int                FB         = 2 * WORD_WIDTH;
  localparam int                CNT_W      = $clog2(FB + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic cs_rise, cs_fall, cs_lvl;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .d     (spi.SCLK),
    .q     (unused_sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // CS resets to its idle (high) level so o_busy stays low through reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .d     (spi.CS),
    .q     (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]  rx_q, rx_d, rx_shift;
  logic [WORD_WIDTH-1:0]  tx_q, tx_d;
  logic                   rw_q, rw_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   load_q, load_d;
  logic                   miso_q, miso_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   rd_strobe_q, rd_strobe_d;
  logic                   ferr_q, ferr_d;
  logic [WORD_WIDTH-1:0]  host_q, host_d;
  logic [WORD_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WORD_WIDTH-1:0]  regs_d [NUM_REGS];
  logic                   in_range;
  logic [WORD_WIDTH-1:0]  rd_val;

  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rx_shift = {rx_q[WORD_WIDTH-2:0], mosi_s};
  assign in_range = ({1'b0, addr_q} < NUM_REGS_W);

  always_comb begin
    mosi_sync_d    = mosi_sync_q << 1;
    mosi_sync_d[0] = spi.MOSI;
  end

  always_comb begin
    rd_val = '0;
    if (addr_q == '0) begin
      rd_val = ID_VALUE;
    end else if (in_range) begin
      rd_val = regs_q[addr_q[HA_W-1:0]];
    end
  end

  always_comb begin
    host_d = (i_host_addr == '0) ? ID_VALUE : regs_q[i_host_addr];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    load_d      = 1'b0;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    ferr_d      = 1'b0;
    regs_d      = regs_q;

    if (load_q) begin
      tx_d = (rw_q == RW_READ) ? rd_val : '0;
    end

    // CS rise is tested before any SCLK edge so it wins a same-cycle tie.
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = ADDR;
          cnt_d   = '0;
          tx_d    = '0;
        end
      end
      ADDR, DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 1'b1;
          if (state_q == ADDR && cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
            rw_d    = rx_shift[RW_BIT];
            addr_d  = rx_shift[ADDR_W-1:0];
            load_d  = 1'b1;
            state_d = DATA;
          end else if (state_q == DATA && cnt_q == CNT_W'(FB - 1)) begin
            state_d = DONE;
            miso_d  = 1'b0;
          end
        end else if (sclk_fall) begin
          miso_d = tx_q[WORD_WIDTH-1];
          tx_d   = tx_q << 1;
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FB)) begin
            if (rw_q == RW_WRITE) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = rx_q;
              if (in_range && addr_q != '0) begin
                regs_d[addr_q[HA_W-1:0]] = rx_q;
              end
            end else begin
              rd_strobe_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= RW_WRITE;
      addr_q      <= '0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      ferr_q      <= 1'b0;
      host_q      <= '0;
      regs_q      <= '{default: '0};
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      ferr_q      <= ferr_d;
      host_q      <= host_d;
      regs_q      <= regs_d;
    end
  end

  // Gating with the raw pin keeps MISO low the instant CS deasserts.
  assign spi.MISO      = miso_q & ~spi.CS;
  assign o_wr_strobe   = wr_strobe_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_rd_strobe   = rd_strobe_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = ~cs_lvl;
  assign o_host_data   = host_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - scoreboard bench for spi_responder
module tb_spi_responder;

  logic       i_clock = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [3:0] i_host_addr = 4'd0;
  logic       o_wr_strobe, o_rd_strobe, o_frame_error, o_busy;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_data, o_host_data;

  spi_responder_if spi ();

  spi_responder dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .spi           (spi),
    .o_wr_strobe   (o_wr_strobe),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_rd_strobe   (o_rd_strobe),
    .o_frame_error (o_frame_error),
    .o_busy        (o_busy),
    .i_host_addr   (i_host_addr),
    .o_host_data   (o_host_data)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_wr_q[$];
  logic [15:0] exp_miso_q[$];
  bit          exp_rd_q[$];
  bit          exp_ferr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  logic [14:0] mon_wr;
  bit          mon_bit;
  always @(negedge i_clock) begin
    if (i_reset_n) begin
      if (o_wr_strobe) begin
        check("wr_strobe_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_addr", 32'(o_wr_addr), 32'(mon_wr[14:8]));
          check("wr_data", 32'(o_wr_data), 32'(mon_wr[7:0]));
        end
      end
      if (o_rd_strobe) begin
        check("rd_strobe_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0) mon_bit = exp_rd_q.pop_front();
      end
      if (o_frame_error) begin
        check("frame_error_expected", 32'(exp_ferr_q.size() != 0), 32'd1);
        if (exp_ferr_q.size() != 0) mon_bit = exp_ferr_q.pop_front();
      end
    end
  end

  int          miso_bits = 0;
  logic [15:0] miso_word = 16'd0;
  logic [15:0] miso_exp;
  always @(negedge spi.CS) begin
    miso_bits = 0;
    miso_word = 16'd0;
  end
  always @(posedge spi.SCLK) begin
    if (spi.CS === 1'b0) begin
      miso_word = {miso_word[14:0], spi.MISO};
      miso_bits++;
    end
  end
  always @(posedge spi.CS) begin
    if (miso_bits == 16) begin
      check("miso_expected", 32'(exp_miso_q.size() != 0), 32'd1);
      if (exp_miso_q.size() != 0) begin
        miso_exp = exp_miso_q.pop_front();
        check("miso_word", 32'(miso_word), 32'(miso_exp));
      end
    end
    miso_bits = 0;
  end

  task automatic frame(input logic [15:0] w, input int nbits, input int half, input bit raise_cs);
    spi.CS = 1'b0;
    repeat (half) @(negedge i_clock);
    for (int i = 0; i < nbits; i++) begin
      spi.MOSI = w[15-i];
      repeat (half) @(negedge i_clock);
      spi.SCLK = 1'b1;
      repeat (half) @(negedge i_clock);
      spi.SCLK = 1'b0;
    end
    repeat (half) @(negedge i_clock);
    if (raise_cs) begin
      spi.CS   = 1'b1;
      spi.MOSI = 1'b0;
      repeat (2 * half) @(negedge i_clock);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, input int half);
    exp_wr_q.push_back({a, d});
    exp_miso_q.push_back(16'h0000);
    frame({1'b0, a, d}, 16, half, 1'b1);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp, input int half);
    exp_rd_q.push_back(1'b1);
    exp_miso_q.push_back({8'h00, exp});
    frame({1'b1, a, 8'h00}, 16, half, 1'b1);
  endtask

  task automatic host(input logic [3:0] a, input logic [7:0] exp, input string name);
    i_host_addr = a;
    repeat (2) @(negedge i_clock);
    check(name, 32'(o_host_data), 32'(exp));
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_wr_strobe"}, 32'(o_wr_strobe), 32'd0);
    check({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
    check({tag, "_rd_strobe"}, 32'(o_rd_strobe), 32'd0);
    check({tag, "_frame_error"}, 32'(o_frame_error), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_host_data"}, 32'(o_host_data), 32'd0);
    check({tag, "_miso"}, 32'(spi.MISO), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    spi.CS   = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    repeat (4) @(negedge i_clock);
    reset_outputs("reset");
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_clock);

    wr(7'h05, 8'h3C, 200);
    host(4'd5, 8'h3C, "host_r5_after_write");

    rd(7'h05, 8'h3C, 20);
    host(4'd5, 8'h3C, "host_r5_after_read");

    rd(7'h00, 8'hA5, 20);
    wr(7'h00, 8'hFF, 20);
    rd(7'h00, 8'hA5, 20);
    host(4'd0, 8'hA5, "host_r0_id");

    rd(7'h10, 8'h00, 20);
    wr(7'h12, 8'h77, 20);
    host(4'd2, 8'h00, "host_r2_no_alias");

    wr(7'h03, 8'h11, 20);
    exp_ferr_q.push_back(1'b1);
    frame(16'h0399, 11, 20, 1'b1);
    host(4'd3, 8'h11, "host_r3_after_abort");

    i_host_addr = 4'd5;
    frame(16'h0744, 5, 20, 1'b0);
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clock);
    reset_outputs("midframe_reset");
    i_reset_n = 1'b1;
    repeat (10) @(negedge i_clock);
    spi.CS = 1'b1;
    repeat (40) @(negedge i_clock);
    wr(7'h07, 8'h44, 20);
    host(4'd7, 8'h44, "host_r7_after_reset");
    host(4'd5, 8'h00, "host_r5_cleared");

    repeat (20) @(negedge i_clock);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("ferr_queue_drained", 32'(exp_ferr_q.size()), 32'd0);
    check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) slave that terminates 16-bit frames of the HDP-1280-2 register protocol.
  - Upper byte: bit7 = R/W (1 = read, 0 = write); bits 6:0 = register address.
  - Lower byte: write data, or read data returned on MISO.
- Holds a small register file readable and writable over SPI. Gives the fabric a write-notify strobe and a read port.
- Used as an SLM stand-in for loopback bring-up of the SPI master, and as a control port for an external MCU.

Parameters:
- WORD_WIDTH, 8: bits per byte; a frame is 2*WORD_WIDTH bits.
- NUM_REGS, 16: register-file depth. Must be a power of 2 and ≤128.
- ID_VALUE, 8'hA5: constant returned by address 0, which is read-only.
- SYNC_STAGES, 2: synchronizer depth on SCLK, CS and MOSI.

Ports:
- i_clock, in, 1: system clock. SCLK must be ≤ i_clock/8.
- i_reset_n, in, 1: asynchronous, active-low reset.
- SCLK, in, 1: SPI clock from the master; asynchronous to i_clock.
- CS, in, 1: active-low chip select; asynchronous.
- MOSI, in, 1: serial data in, MSB first.
- MISO, out, 1: serial data out, MSB first. Driven 0 whenever CS is high; never tri-stated.
- o_wr_strobe, out, 1: one-cycle pulse when a write frame completes.
- o_wr_addr, out, 7: address of the completed write.
- o_wr_data, out, WORD_WIDTH: data of the completed write.
- o_rd_strobe, out, 1: one-cycle pulse when a read frame completes.
- o_frame_error, out, 1: one-cycle pulse when a frame aborts (CS rises at a bit count other than 0 or 16).
- o_busy, out, 1: synchronized CS low.
- i_host_addr, in, log2(NUM_REGS): fabric read address.
- o_host_data, out, WORD_WIDTH: register at i_host_addr, registered with 1-cycle latency.

Behaviour:
- Reset values (asynchronous):
  - All outputs 0; MISO 0.
  - All registers 0, except address 0, which reads ID_VALUE at all times.
  - State IDLE; bit counter 0.
- Input synchronization:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flops.
  - SCLK rise/fall and CS fall/rise are detected from the last two synchronized samples.
  - All logic runs on i_clock; there is no SCLK-clocked logic.
- State machine states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - CS fall → ADDR; bit counter = 0; tx shift = 0x00.
- ADDR:
  - Each SCLK rise: shift MOSI into rx and increment the counter.
  - On the 8th rise: latch rw = rx[7] and addr = rx[6:0].
  - On a read, load the tx shift with the read value on the cycle after the 8th rise:
    - address 0 → ID_VALUE;
    - address < NUM_REGS → register contents;
    - otherwise 0x00.
  - Go to DATA.
- DATA:
  - Each SCLK rise: shift MOSI into rx.
  - On the 16th rise → DONE.
- DONE:
  - Further SCLK edges are ignored; MISO stays 0.
  - On CS rise, with counter == 16:
    - Write frame: commit the register only if addr < NUM_REGS and addr != 0; pulse o_wr_strobe with addr and data regardless of range.
    - Read frame: pulse o_rd_strobe.
  - Return to IDLE.
- MISO timing:
  - Updates on the synchronized SCLK fall: shift tx left, MISO = tx MSB.
  - Upper byte returns 0x00.
  - The read data MSB appears on the 8th fall, ready for the 9th rise.
  - A write frame returns 0x00 in the lower byte.
- Abort:
  - CS rise in ADDR or DATA → pulse o_frame_error, no write, return to IDLE.
  - CS fall while already active is impossible; a glitch shorter than the synchronizer is not required to be seen.
- Simultaneous events:
  - A CS rise detected in the same cycle as an SCLK rise: the CS rise wins.
  - A fabric read of a register in the same cycle as its SPI commit returns the old value; the new value appears the next cycle.
- Reset mid-frame: immediate return to IDLE. The next frame requires a fresh CS fall.

Decomposition:
- Shared package spi_pkg:
  - WORD_WIDTH;
  - the R/W bit position and the RW_READ = 1 / RW_WRITE = 0 encodings;
  - the state encodings IDLE/ADDR/DATA/DONE;
  - FRAME_BITS = 16.
- One sub-module, spi_sync_edge: an N-stage synchronizer plus rise/fall detector, instantiated for SCLK and CS. MOSI uses the synchronizer only.

Test Plan:
- Write frame 0x05,0x3C (SCLK = i_clock/400) → o_wr_strobe 1 cycle with addr 5, data 0x3C; i_host_addr=5 gives o_host_data=0x3C one cycle later; MISO returns 0x0000.
- Read frame 0x85,0x00 after that write → MISO bits read 0x003C; o_rd_strobe pulses once; register unchanged.
- Read of address 0 (0x80,0x00) → 0x00A5 on MISO. Write 0x00,0xFF → strobe fires, but address 0 still reads 0xA5.
- Out-of-range read 0x90 with NUM_REGS=16 → 0x0000. Write 0x12,0x77 → strobe with addr 0x12; no register changes.
- CS raised after 11 SCLK rises of write 0x03,0x99 → o_frame_error pulses; register 3 keeps its prior value; no o_wr_strobe.
- i_reset_n pulsed low after 5 bits, then a full frame 0x07,0x44 → clean write of 0x44 to register 7; all outputs were 0 during reset.
